// File: rtl/mem_seq_pkg.sv
// ============================================================================
// mem_seq_pkg : shared types and decode helpers for the memory access sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_seq_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  function automatic logic is_store(input mem_op_t op);
    return (op >= OP_SW);
  endfunction

  function automatic acc_size_t access_size(input mem_op_t op);
    acc_size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    logic bad;
    case (access_size(op))
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_unit.sv
// ============================================================================
// mem_lane_unit : little-endian lane select/extend for loads, lane merge for stores
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_lane_unit
  import mem_seq_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  mem_op_t     op_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    case (op_i)
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'd0, byte_sel};
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase

    // Sub-word stores keep the untouched lanes of the word just read
    merged_o = word_i;
    case (op_i)
      OP_SB: begin
        case (byte_off_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      OP_SH: begin
        if (byte_off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else               merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
// ============================================================================
// mem_access_seq : one-at-a-time load/store sequencer for a single-port word memory
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

  seq_state_t  state_q;
  mem_op_t     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic        mem_wr_q;
  logic [31:0] mem_wdata_q;

  mem_op_t     op_in;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  assign op_in = mem_op_t'(op_i);

  mem_lane_unit u_lane (
    .word_i     (mem_rdata_i),
    .byte_off_i (addr_q[1:0]),
    .op_i       (op_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merged_o   (merged_word)
  );

  // Every output is a flop so memory-side strobes never glitch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            op_q    <= op_in;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (is_misaligned(op_in, addr_i[1:0])) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (op_in == OP_SW) begin
              state_q     <= S_WR;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= wdata_i;
            end else begin
              state_q    <= S_RD;
              mem_addr_q <= {addr_i[31:2], 2'b00};
            end
          end
        end
        S_RD: begin
          if (cnt_q == LAST_CNT) begin
            if (is_store(op_q)) begin
              state_q     <= S_WR;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= merged_word;
            end else begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              rdata_q    <= load_val;
              mem_addr_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_WR: begin
          state_q    <= S_DONE;
          done_q     <= 1'b1;
          mem_addr_q <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// ============================================================================
// tb_mem_access_seq : directed self-checking bench for mem_access_seq
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_seq;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk, rst_n, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int vec  = 0;
  int errs = 0;

  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  mem_access_seq #(.READ_LAT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .op_i        (op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .rdata_o     (rdata),
    .mem_addr_o  (mem_addr),
    .mem_wr_o    (mem_wr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request and observes cycles 1..16 relative to acceptance
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        output int dcyc, output logic e, output int nwr, output int wcyc,
                        output logic [31:0] waddr, output logic [31:0] wdat);
    dcyc = -1; e = 1'b0; nwr = 0; wcyc = -1; waddr = '0; wdat = '0;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (mem_wr) begin nwr++; wcyc = k; waddr = mem_addr; wdat = mem_wdata; end
      if (done) begin dcyc = k; e = err; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int dc, nw, wc; logic e; logic [31:0] wa, wd;
    rst_n = 1'b0; req = 1'b0; op = LW; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    vec++;
    if ({busy, done, err, mem_wr} !== 4'b0 || rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errs++; $display("FAIL reset_init: busy/done/err/wr=%b rdata=%h maddr=%h mwdata=%h required all 0",
                       {busy, done, err, mem_wr}, rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req = 1'b1; op = LW; addr = 32'h40;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, done, err, mem_wr} !== 4'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errs++; $display("FAIL reset_mid: busy/done/err/wr=%b maddr=%h mwdata=%h required all 0",
                       {busy, done, err, mem_wr}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(LW, 32'h44, 32'd0, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 3 || rdata !== 32'h0BADF00D) begin
      errs++; $display("FAIL reset_first_req: done_cyc=%0d rdata=%h required 3 0badf00d", dc, rdata);
    end
  endtask

  task automatic test_sw();
    @(negedge clk);
    req = 1'b1; op = SW; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    vec++;
    if (mem_wr !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || done !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL sw_cyc1: wr=%b maddr=%h mwdata=%h done=%b busy=%b required 1 10 deadbeef 0 1",
                       mem_wr, mem_addr, mem_wdata, done, busy);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b1 || err !== 1'b0 || mem_wr !== 1'b0) begin
      errs++; $display("FAIL sw_cyc2: done=%b err=%b wr=%b required 1 0 0", done, err, mem_wr);
    end
    @(negedge clk);
    vec++;
    if (mem[4] !== 32'hDEADBEEF || busy !== 1'b0 || mem_wdata !== 32'd0) begin
      errs++; $display("FAIL sw_mem: mem=%h busy=%b mwdata=%h required deadbeef 0 0", mem[4], busy, mem_wdata);
    end
  endtask

  task automatic test_loads();
    int dc, nw, wc; logic e; logic [31:0] wa, wd;
    logic [2:0]  ops [0:6];
    logic [31:0] adrs [0:6];
    logic [31:0] exp  [0:6];
    ops[0] = LB;  adrs[0] = 32'h13; exp[0] = 32'hFFFFFF80;
    ops[1] = LBU; adrs[1] = 32'h13; exp[1] = 32'h00000080;
    ops[2] = LH;  adrs[2] = 32'h12; exp[2] = 32'hFFFF80FF;
    ops[3] = LHU; adrs[3] = 32'h12; exp[3] = 32'h000080FF;
    ops[4] = LW;  adrs[4] = 32'h10; exp[4] = 32'h80FF7F01;
    ops[5] = LB;  adrs[5] = 32'h11; exp[5] = 32'h0000007F;
    ops[6] = LH;  adrs[6] = 32'h10; exp[6] = 32'h00007F01;
    preload(6'd4, 32'h80FF7F01);
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], adrs[i], 32'd0, dc, e, nw, wc, wa, wd);
      vec++;
      if (dc !== 3 || e !== 1'b0 || nw !== 0 || rdata !== exp[i]) begin
        errs++; $display("FAIL load_%0d: done_cyc=%0d err=%b writes=%0d rdata=%h required 3 0 0 %h",
                         i, dc, e, nw, rdata, exp[i]);
      end
    end
  endtask

  task automatic test_sub_store();
    int dc, nw, wc; logic e; logic [31:0] wa, wd;
    preload(6'd8, 32'h11223344);
    run_op(SH, 32'h22, 32'h0000ABCD, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 4 || e !== 1'b0 || nw !== 1 || wc !== 3 || wa !== 32'h20 || wd !== 32'hABCD3344) begin
      errs++; $display("FAIL sh_rmw: done=%0d err=%b nwr=%0d wcyc=%0d waddr=%h wdat=%h required 4 0 1 3 20 abcd3344",
                       dc, e, nw, wc, wa, wd);
    end
    vec++;
    if (mem[8] !== 32'hABCD3344 || rdata !== 32'h00007F01) begin
      errs++; $display("FAIL sh_mem: mem=%h rdata=%h required abcd3344 00007f01", mem[8], rdata);
    end
    run_op(SB, 32'h21, 32'hFFFFFF55, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 4 || nw !== 1 || wc !== 3 || wd !== 32'hABCD5544 || mem[8] !== 32'hABCD5544) begin
      errs++; $display("FAIL sb_rmw: done=%0d nwr=%0d wcyc=%0d wdat=%h mem=%h required 4 1 3 abcd5544 abcd5544",
                       dc, nw, wc, wd, mem[8]);
    end
  endtask

  task automatic test_misaligned();
    int dc, nw, wc; logic e; logic [31:0] wa, wd;
    run_op(LW, 32'h06, 32'd0, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 1 || e !== 1'b1 || nw !== 0 || rdata !== 32'h00007F01) begin
      errs++; $display("FAIL mis_lw: done=%0d err=%b nwr=%0d rdata=%h required 1 1 0 00007f01", dc, e, nw, rdata);
    end
    run_op(SH, 32'h21, 32'h00009999, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 1 || e !== 1'b1 || nw !== 0 || mem[8] !== 32'hABCD5544) begin
      errs++; $display("FAIL mis_sh: done=%0d err=%b nwr=%0d mem=%h required 1 1 0 abcd5544", dc, e, nw, mem[8]);
    end
  endtask

  task automatic test_busy();
    int ndone, nwr, dc, nw, wc; logic e; logic [31:0] wa, wd;
    @(negedge clk);
    req = 1'b1; op = LW; addr = 32'h10;
    @(negedge clk);
    vec++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL busy_high: busy=%b required 1", busy);
    end
    op = SW; addr = 32'h30; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    ndone = 0; nwr = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      if (mem_wr) nwr++;
      @(negedge clk);
    end
    vec++;
    if (ndone !== 1 || nwr !== 0 || busy !== 1'b0 || rdata !== 32'h80FF7F01) begin
      errs++; $display("FAIL busy_ignore: dones=%0d writes=%0d busy=%b rdata=%h required 1 0 0 80ff7f01",
                       ndone, nwr, busy, rdata);
    end
    preload(6'd9, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; op = SB; addr = 32'h25; wdata = 32'h77;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL rst_sb: busy=%b wr=%b done=%b required 0 0 0", busy, mem_wr, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (mem[9] !== 32'hCAFEF00D) begin
      errs++; $display("FAIL rst_sb_mem: mem=%h required cafef00d", mem[9]);
    end
    run_op(LW, 32'h24, 32'd0, dc, e, nw, wc, wa, wd);
    vec++;
    if (dc !== 3 || rdata !== 32'hCAFEF00D) begin
      errs++; $display("FAIL rst_sb_after: done_cyc=%0d rdata=%h required 3 cafef00d", dc, rdata);
    end
  endtask

  initial begin
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[17] = 32'h0BADF00D;
    test_reset();
    test_sw();
    test_loads();
    test_sub_store();
    test_misaligned();
    test_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
